// File: rtl/fma_sign_pkg.sv
// fma_sign_pkg: rounding-mode and op encodings, the per-stage payload,
// and the combinational sign-resolution function used at pipeline entry.
package fma_sign_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  typedef enum logic [1:0] {
    OP_FMADD  = 2'b00,
    OP_FMSUB  = 2'b01,
    OP_FNMSUB = 2'b10,
    OP_FNMADD = 2'b11
  } op_e;

  typedef struct packed {
    logic wsign;
    logic invz;
    logic negsum;
    logic selsum1;
    logic psign;
    logic bad_rm;
  } payload_t;

  function automatic payload_t resolve_sign(
    input logic       xsign,
    input logic       ysign,
    input logic       zsign,
    input logic [1:0] op,
    input logic       negsum0,
    input logic       negsum1,
    input logic       bs,
    input logic       ps,
    input logic       killprod,
    input logic       sumzero,
    input logic       invalid,
    input logic       zinf,
    input logic       inf,
    input logic [2:0] rm
  );
    payload_t r;
    logic     zs;
    logic     zerosign;
    logic     infsign;
    r         = '0;
    r.psign   = xsign ^ ysign ^ op[1];
    zs        = zsign ^ op[0];
    r.invz    = zs ^ r.psign;
    if (!r.invz) begin
      r.selsum1 = 1'b0;
      r.negsum  = 1'b0;
    end else if (bs) begin
      r.selsum1 = 1'b0;
      r.negsum  = negsum0;
    end else if (ps) begin
      r.selsum1 = 1'b1;
      r.negsum  = negsum1;
    end else begin
      r.selsum1 = negsum1;
      r.negsum  = negsum1;
    end
    // Reserved modes behave as RNE here: only RDN produces a negative exact zero.
    r.bad_rm  = (rm > RM_RMM);
    zerosign  = (!r.invz && killprod) ? zs : (rm == RM_RDN);
    infsign   = zinf ? zs : r.psign;
    if (invalid)      r.wsign = 1'b0;
    else if (inf)     r.wsign = infsign;
    else if (sumzero) r.wsign = zerosign;
    else              r.wsign = r.psign ^ r.negsum;
    return r;
  endfunction

endpackage

// File: rtl/fma_sign_stage.sv
// fma_sign_stage: one elastic valid/payload register; loads on advance,
// empties on flush.
module fma_sign_stage
  import fma_sign_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     flush,
  input  logic     advance,
  input  logic     prev_valid,
  input  payload_t prev_data,
  output logic     valid,
  output payload_t data
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (advance) begin
      valid <= prev_valid;
      if (prev_valid) data <= prev_data;
    end
  end

endmodule

// File: rtl/fma_sign_pipe.sv
// fma_sign_pipe: FMA result-sign resolution carried through STAGES elastic stages.
// Define FMA_SIGN_NEGOP_EN to honour the op negation bits; otherwise op is ignored (fmadd).
module fma_sign_pipe
  import fma_sign_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  input  logic       xsign,
  input  logic       ysign,
  input  logic       zsign,
  input  logic [1:0] op,
  input  logic       negsum0,
  input  logic       negsum1,
  input  logic       bs,
  input  logic       ps,
  input  logic       killprod,
  input  logic       sumzero,
  input  logic       invalid,
  input  logic       zinf,
  input  logic       inf,
  input  logic [2:0] rm,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       wsign,
  output logic       invz,
  output logic       negsum,
  output logic       selsum1,
  output logic       psign,
  output logic       bad_rm
);

  logic [1:0]      op_eff;
  logic [STAGES:0] vld;
  logic [STAGES:0] advance;
  payload_t        pl [STAGES+1];

`ifdef FMA_SIGN_NEGOP_EN
  assign op_eff = op;
`else
  logic [1:0] op_unused;
  assign op_unused = op;
  assign op_eff    = OP_FMADD;
`endif

  assign vld[0] = in_valid;
  assign pl[0]  = resolve_sign(xsign, ysign, zsign, op_eff, negsum0, negsum1, bs, ps,
                               killprod, sumzero, invalid, zinf, inf, rm);

  // Stage i may load when it is empty or the stage after it is loading.
  always_comb begin
    advance         = '0;
    advance[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--)
      advance[i] = ~vld[i+1] | advance[i+1];
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    fma_sign_stage u_stage (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .advance    (advance[i]),
      .prev_valid (vld[i]),
      .prev_data  (pl[i]),
      .valid      (vld[i+1]),
      .data       (pl[i+1])
    );
  end

  assign in_ready  = advance[0];
  assign out_valid = vld[STAGES];
  assign wsign     = pl[STAGES].wsign;
  assign invz      = pl[STAGES].invz;
  assign negsum    = pl[STAGES].negsum;
  assign selsum1   = pl[STAGES].selsum1;
  assign psign     = pl[STAGES].psign;
  assign bad_rm    = pl[STAGES].bad_rm;

endmodule

// File: tb/tb_fma_sign_pipe.sv
// tb_fma_sign_pipe: scoreboard bench for fma_sign_pipe (STAGES=2); expected
// payloads are queued on acceptance and compared when the pipe emits them.
module tb_fma_sign_pipe;

  typedef struct packed {
    logic       x;
    logic       y;
    logic       z;
    logic [1:0] op;
    logic       negsum0;
    logic       negsum1;
    logic       bs;
    logic       ps;
    logic       killprod;
    logic       sumzero;
    logic       invalid;
    logic       zinf;
    logic       inf;
    logic [2:0] rm;
  } stim_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic       xsign = 1'b0, ysign = 1'b0, zsign = 1'b0;
  logic [1:0] op = 2'b00;
  logic       negsum0 = 1'b0, negsum1 = 1'b0, bs = 1'b0, ps = 1'b0, killprod = 1'b0;
  logic       sumzero = 1'b0, invalid = 1'b0, zinf = 1'b0, inf = 1'b0;
  logic [2:0] rm = 3'b000;
  wire        in_ready, out_valid, wsign, invz, negsum, selsum1, psign, bad_rm;
  wire  [5:0] out_vec = {wsign, invz, negsum, selsum1, psign, bad_rm};

  int         checks = 0;
  int         errors = 0;
  logic [5:0] sb [$];
  logic       snap_valid, snap_ready;
  logic [5:0] snap_out;

  fma_sign_pipe #(.STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .xsign(xsign), .ysign(ysign), .zsign(zsign), .op(op),
    .negsum0(negsum0), .negsum1(negsum1), .bs(bs), .ps(ps), .killprod(killprod),
    .sumzero(sumzero), .invalid(invalid), .zinf(zinf), .inf(inf), .rm(rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .wsign(wsign), .invz(invz), .negsum(negsum), .selsum1(selsum1), .psign(psign),
    .bad_rm(bad_rm)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: returns {wsign, invz, negsum, selsum1, psign, bad_rm}.
  function automatic logic [5:0] model(input stim_t s);
    logic [1:0] o;
    logic p, za, iz, sel, ng, zsg, w, bad;
`ifdef FMA_SIGN_NEGOP_EN
    o = s.op;
`else
    o = 2'b00;
`endif
    p  = s.x ^ s.y ^ o[1];
    za = s.z ^ o[0];
    iz = (p != za);
    if (!iz)       begin sel = 1'b0;      ng = 1'b0;      end
    else if (s.bs) begin sel = 1'b0;      ng = s.negsum0; end
    else if (s.ps) begin sel = 1'b1;      ng = s.negsum1; end
    else           begin sel = s.negsum1; ng = s.negsum1; end
    bad = (s.rm >= 3'd5);
    if (!iz && s.killprod) zsg = za;
    else                   zsg = (s.rm == 3'b010);
    if (s.invalid)      w = 1'b0;
    else if (s.inf)     w = s.zinf ? za : p;
    else if (s.sumzero) w = zsg;
    else                w = p ^ ng;
    return {w, iz, ng, sel, p, bad};
  endfunction

  task automatic applyStimulus(input stim_t s, input logic iv, input logic ordy, input logic fl,
                               input logic use_exp, input logic [5:0] expv, output logic acc);
    logic [5:0] e;
    @(negedge clk);
    xsign = s.x; ysign = s.y; zsign = s.z; op = s.op;
    negsum0 = s.negsum0; negsum1 = s.negsum1; bs = s.bs; ps = s.ps; killprod = s.killprod;
    sumzero = s.sumzero; invalid = s.invalid; zinf = s.zinf; inf = s.inf; rm = s.rm;
    in_valid = iv; out_ready = ordy; flush = fl;
    #1;
    snap_valid = out_valid;
    snap_ready = in_ready;
    snap_out   = out_vec;
    acc = iv && in_ready && !fl;
    if (!fl && out_valid && out_ready) begin
      if (sb.size() == 0) checkOutput("unexpected_out", 1, 0);
      else begin
        e = sb.pop_front();
        checkOutput("payload", out_vec, e);
      end
    end
    if (acc) sb.push_back(use_exp ? expv : model(s));
    @(posedge clk);
  endtask

  task automatic drain(input int n);
    stim_t z;
    logic  a;
    z = '0;
    for (int j = 0; j < n; j++) applyStimulus(z, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, a);
  endtask

  initial begin
    stim_t      s;
    stim_t      ent [4];
    logic       acc, saw_stall, prev_hold, ordy;
    logic [5:0] prev_out;
    logic [16:0] r;
    int         idx, k;

    #1 reset_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_payload", out_vec, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Latency and the invz/bs path.
    s = '0; s.y = 1'b1; s.bs = 1'b1; s.negsum0 = 1'b1;
    applyStimulus(s, 1'b1, 1'b1, 1'b0, 1'b1, 6'b011010, acc);
    checkOutput("lat_accept", acc, 1);
    s = '0;
    applyStimulus(s, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, acc);
    checkOutput("lat_cycle1_valid", snap_valid, 0);
    applyStimulus(s, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, acc);
    checkOutput("lat_cycle2_valid", snap_valid, 1);

    // Exact-zero sign under RDN, RNE and a reserved mode.
    s = '0; s.z = 1'b1; s.sumzero = 1'b1; s.rm = 3'b010;
    applyStimulus(s, 1'b1, 1'b1, 1'b0, 1'b1, 6'b110000, acc);
    s.rm = 3'b000;
    applyStimulus(s, 1'b1, 1'b1, 1'b0, 1'b1, 6'b010000, acc);
    s.rm = 3'b110;
    applyStimulus(s, 1'b1, 1'b1, 1'b0, 1'b1, 6'b010001, acc);

    // Infinity and invalid with fnmadd.
    s = '0; s.op = 2'b11; s.inf = 1'b1;
`ifdef FMA_SIGN_NEGOP_EN
    applyStimulus(s, 1'b1, 1'b1, 1'b0, 1'b1, 6'b100010, acc);
    s.invalid = 1'b1;
    applyStimulus(s, 1'b1, 1'b1, 1'b0, 1'b1, 6'b000010, acc);
`else
    applyStimulus(s, 1'b1, 1'b1, 1'b0, 1'b1, 6'b000000, acc);
    s.invalid = 1'b1;
    applyStimulus(s, 1'b1, 1'b1, 1'b0, 1'b1, 6'b000000, acc);
`endif
    drain(3);
    checkOutput("directed_drain", sb.size(), 0);

    // Backpressure: out_ready low for cycles 2-5 of a 4-entry burst.
    for (int j = 0; j < 4; j++) begin
      r = 17'($urandom);
      ent[j] = r;
    end
    idx = 0; k = 0; saw_stall = 1'b0; prev_hold = 1'b0; prev_out = '0;
    while ((idx < 4 || sb.size() != 0) && k < 20) begin
      k++;
      ordy = !(k >= 2 && k <= 5);
      applyStimulus(ent[idx < 4 ? idx : 0], idx < 4, ordy, 1'b0, 1'b0, 6'd0, acc);
      if (prev_hold) begin
        checkOutput("hold_valid", snap_valid, 1);
        checkOutput("hold_payload", snap_out, prev_out);
      end
      if (k == 2) checkOutput("fill_ready_k2", snap_ready, 1);
      if (k == 3) checkOutput("fill_ready_k3", snap_ready, 0);
      prev_hold = !ordy && snap_valid;
      prev_out  = snap_out;
      if (!snap_ready) saw_stall = 1'b1;
      if (acc) idx++;
    end
    checkOutput("fill_complete", (idx == 4 && sb.size() == 0), 1);
    checkOutput("fill_stall_seen", saw_stall, 1);

    // Flush with two entries in flight and a new input offered.
    for (int j = 0; j < 2; j++) begin
      r = 17'($urandom);
      s = r;
      applyStimulus(s, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, acc);
    end
    r = 17'($urandom);
    s = r;
    applyStimulus(s, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, acc);
    checkOutput("pre_flush_valid", snap_valid, 1);
    sb.delete();
    s = '0;
    applyStimulus(s, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, acc);
    checkOutput("flush_out_valid", snap_valid, 0);
    drain(3);

    // Asynchronous reset mid-stream.
    for (int j = 0; j < 2; j++) begin
      r = 17'($urandom);
      s = r;
      applyStimulus(s, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, acc);
    end
    #1;
    checkOutput("pre_reset_valid", out_valid, 1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid", out_valid, 0);
    checkOutput("rst_mid_payload", out_vec, 0);
    sb.delete();
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    r = 17'($urandom);
    s = r;
    applyStimulus(s, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, acc);
    checkOutput("ready_after_reset", snap_ready, 1);

    // Random traffic with random backpressure.
    for (int j = 0; j < 60; j++) begin
      r = 17'($urandom);
      s = r;
      applyStimulus(s, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0, 1'b0,
                    6'd0, acc);
    end
    drain(6);
    checkOutput("random_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fma_sign_pipe.md
FMA_SIGN_PIPE -- requirements
Module: fma_sign_pipe

Interface
REQ-001 SHALL have parameter STAGES, default 2, number of elastic register stages (legal 1..4).
REQ-002 SHALL have ports: clk in 1 clock; reset_n in 1 asynchronous active-low reset.
REQ-003 SHALL have ports: in_valid in 1 operand valid; in_ready out 1 stage 0 can accept; flush in 1 discard all in-flight entries.
REQ-004 SHALL have ports: xsign, ysign, zsign in 1 each, operand signs; op in 2, op[1] negates product, op[0] negates addend (fmadd=00, fmsub=01, fnmsub=10, fnmadd=11).
REQ-005 SHALL have ports: negsum0, negsum1, bs, ps, killprod, sumzero, invalid, zinf, inf in 1 each, adder and special-case status; rm in 3, RISC-V rounding mode.
REQ-006 SHALL have ports: out_valid out 1; out_ready in 1; wsign, invz, negsum, selsum1, psign out 1 each; bad_rm out 1, rm was reserved (101, 110, 111).

Function
REQ-007 SHALL compute at stage-0 input: psign = xsign^ysign^op[1]; zs = zsign^op[0]; invz = zs^psign.
REQ-008 SHALL compute selsum1/negsum as: ~invz -> 0/0; else bs -> 0/negsum0; else ps -> 1/negsum1; else negsum1/negsum1.
REQ-009 SHALL compute zerosign = (~invz & killprod) ? zs : (rm==010); infsign = zinf ? zs : psign.
REQ-010 SHALL compute wsign = invalid ? 0 : inf ? infsign : sumzero ? zerosign : psign^negsum.
REQ-011 SHALL treat reserved rm as RNE for zerosign and carry bad_rm=1 with that entry.
REQ-012 SHALL register results through STAGES stages; latency is exactly STAGES cycles from in_valid&in_ready to out_valid when out_ready stays 1.
REQ-013 SHALL advance stage i when its valid is 0 or stage i+1 (or out_ready at the last stage) accepts; in_ready = stage 0 advance condition, combinational from out_ready.
REQ-014 SHALL sustain one entry per cycle with out_ready=1; with out_ready=0 SHALL hold all outputs stable and fill up to STAGES entries, then drop in_ready.
REQ-015 SHALL, on flush, clear every stage valid at the next edge; an input presented in the flush cycle is not captured; flush overrides out_ready.
REQ-016 SHALL preserve entry order; no entry is duplicated or lost except by flush.

Reset
REQ-017 SHALL, while reset_n=0, clear all stage valids asynchronously; out_valid=0, wsign=invz=negsum=selsum1=psign=bad_rm=0.
REQ-018 SHALL drop in-flight entries on reset assertion mid-operation; in_ready=1 on the first edge after release.

Configuration
REQ-019 SHALL honour macro FMA_SIGN_NEGOP_EN: defined -> op decoded per REQ-004/007; undefined -> op ignored, treated as 00 (plain fmadd), op storage removed.

Structure
REQ-020 SHALL place rm encodings (RNE 000, RTZ 001, RDN 010, RUP 011, RMM 100), op encodings, and the stage payload struct (signs, control bits, bad_rm) in package fma_sign_pkg.
REQ-021 SHALL use one sub-module fma_sign_stage (single valid/ready payload register with flush), instantiated STAGES times by generate.

Verification
REQ-022 SHALL cover: STAGES=2, x=0,y=1,z=0, op=00, invz path, bs=1, negsum0=1, sumzero=0 -> after 2 cycles invz=1, selsum1=0, negsum=1, psign=1, wsign=0.
REQ-023 SHALL cover: x=0,y=0,z=1, sumzero=1, killprod=0, rm=010 -> wsign=1; same with rm=000 -> wsign=0; rm=110 -> wsign=0, bad_rm=1.
REQ-024 SHALL cover: op=11, x=0,y=0,z=0, inf=1, zinf=0 -> psign=1, wsign=1; same with invalid=1 -> wsign=0; without FMA_SIGN_NEGOP_EN -> psign=0, wsign=0.
REQ-025 SHALL cover: 4 back-to-back inputs, out_ready=0 for cycles 2-5 -> in_ready falls after STAGES fills, outputs held, all 4 emerge in order once out_ready=1.
REQ-026 SHALL cover: 2 entries in flight plus in_valid=1 with flush=1 -> out_valid=0 next cycle, no entry emerges; reset_n pulsed mid-stream -> out_valid=0 immediately.
